// File: rtl/avm_arb2.sv
// Two-requester round-robin Avalon-MM arbiter with a per-transfer grant and a stall watchdog.
// The granted requester is wired straight through to the shared slave port.
module avm_arb2 #(
  parameter int unsigned            ADDR_W       = 32,
  parameter int unsigned            DATA_W       = 32,
  parameter int unsigned            TIMEOUT      = 1024,
  parameter logic [DATA_W-1:0]      TIMEOUT_DATA = 32'hDEAD_BEEF
) (
  input  logic                  clk_clk,
  input  logic                  reset_reset_n,
  input  logic                  s0_cs,
  input  logic                  s0_read,
  input  logic                  s0_write,
  input  logic [ADDR_W-1:0]     s0_address,
  input  logic [DATA_W-1:0]     s0_writedata,
  input  logic [DATA_W/8-1:0]   s0_byteenable,
  output logic                  s0_waitrequest,
  output logic [DATA_W-1:0]     s0_readdata,
  input  logic                  s1_cs,
  input  logic                  s1_read,
  input  logic                  s1_write,
  input  logic [ADDR_W-1:0]     s1_address,
  input  logic [DATA_W-1:0]     s1_writedata,
  input  logic [DATA_W/8-1:0]   s1_byteenable,
  output logic                  s1_waitrequest,
  output logic [DATA_W-1:0]     s1_readdata,
  output logic                  m_cs,
  output logic                  m_read,
  output logic                  m_write,
  output logic [ADDR_W-1:0]     m_address,
  output logic [DATA_W-1:0]     m_writedata,
  output logic [DATA_W/8-1:0]   m_byteenable,
  input  logic                  m_waitrequest,
  input  logic [DATA_W-1:0]     m_readdata,
  output logic                  timeout_o
);

  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int unsigned TLAST = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;
  localparam logic [CNT_W-1:0] CNT_LAST = TLAST[CNT_W-1:0];
  localparam logic WD_EN = (TIMEOUT != 0);

  typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_e;

  state_e           state_q, state_d;
  logic             last_gnt_q, last_gnt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic req0, req1, sel_req, tmo;

  always_comb begin
    req0    = s0_cs & (s0_read | s0_write);
    req1    = s1_cs & (s1_read | s1_write);
    sel_req = (state_q == GNT1) ? req1 : req0;
    tmo     = WD_EN && (state_q != IDLE) && sel_req && m_waitrequest && (cnt_q == CNT_LAST);
  end

  // Datapath: pure steering; a watchdog cycle masks the strobes and fakes completion.
  always_comb begin
    m_cs           = 1'b0;
    m_read         = 1'b0;
    m_write        = 1'b0;
    m_address      = '0;
    m_writedata    = '0;
    m_byteenable   = '0;
    s0_waitrequest = 1'b1;
    s1_waitrequest = 1'b1;
    s0_readdata    = '0;
    s1_readdata    = '0;
    timeout_o      = tmo;
    case (state_q)
      GNT0: begin
        m_cs           = s0_cs & ~tmo;
        m_read         = s0_read & ~tmo;
        m_write        = s0_write & ~tmo;
        m_address      = s0_address;
        m_writedata    = s0_writedata;
        m_byteenable   = s0_byteenable;
        s0_waitrequest = m_waitrequest & ~tmo;
        s0_readdata    = tmo ? TIMEOUT_DATA : m_readdata;
      end
      GNT1: begin
        m_cs           = s1_cs & ~tmo;
        m_read         = s1_read & ~tmo;
        m_write        = s1_write & ~tmo;
        m_address      = s1_address;
        m_writedata    = s1_writedata;
        m_byteenable   = s1_byteenable;
        s1_waitrequest = m_waitrequest & ~tmo;
        s1_readdata    = tmo ? TIMEOUT_DATA : m_readdata;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    last_gnt_d = last_gnt_q;
    cnt_d      = '0;
    case (state_q)
      IDLE: begin
        // On a tie, the requester that did not complete last wins.
        if (req0 && (!req1 || last_gnt_q)) state_d = GNT0;
        else if (req1)                     state_d = GNT1;
      end
      GNT0, GNT1: begin
        if (!sel_req) begin
          state_d = IDLE;
        end else if (!m_waitrequest || tmo) begin
          state_d    = IDLE;
          last_gnt_d = (state_q == GNT1);
        end else if (WD_EN) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q    <= IDLE;
      last_gnt_q <= 1'b1;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      last_gnt_q <= last_gnt_d;
      cnt_q      <= cnt_d;
    end
  end

endmodule

// File: tb/tb_avm_arb2.sv
// Bench for avm_arb2: directed scenarios with literal expectations, then random traffic
// checked every cycle against a transaction-level arbitration model.
module tb_avm_arb2;

  localparam int TMO = 8;
  localparam logic [31:0] TDATA = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cs_a [2];
  logic        rd_a [2];
  logic        wr_a [2];
  logic [31:0] ad_a [2];
  logic [31:0] wd_a [2];
  logic [3:0]  be_a [2];
  logic        s0_waitrequest, s1_waitrequest;
  logic [31:0] s0_readdata, s1_readdata;
  logic        m_cs, m_read, m_write, m_waitrequest, timeout_o;
  logic [31:0] m_address, m_writedata, m_readdata;
  logic [3:0]  m_byteenable;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  avm_arb2 #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TMO), .TIMEOUT_DATA(TDATA)) dut (
    .clk_clk        (clk),
    .reset_reset_n  (rst_n),
    .s0_cs          (cs_a[0]),
    .s0_read        (rd_a[0]),
    .s0_write       (wr_a[0]),
    .s0_address     (ad_a[0]),
    .s0_writedata   (wd_a[0]),
    .s0_byteenable  (be_a[0]),
    .s0_waitrequest (s0_waitrequest),
    .s0_readdata    (s0_readdata),
    .s1_cs          (cs_a[1]),
    .s1_read        (rd_a[1]),
    .s1_write       (wr_a[1]),
    .s1_address     (ad_a[1]),
    .s1_writedata   (wd_a[1]),
    .s1_byteenable  (be_a[1]),
    .s1_waitrequest (s1_waitrequest),
    .s1_readdata    (s1_readdata),
    .m_cs           (m_cs),
    .m_read         (m_read),
    .m_write        (m_write),
    .m_address      (m_address),
    .m_writedata    (m_writedata),
    .m_byteenable   (m_byteenable),
    .m_waitrequest  (m_waitrequest),
    .m_readdata     (m_readdata),
    .timeout_o      (timeout_o)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic drv(input int n, input logic cs, input logic rd, input logic wr,
                     input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    cs_a[n] = cs; rd_a[n] = rd; wr_a[n] = wr; ad_a[n] = a; wd_a[n] = d; be_a[n] = be;
  endtask

  // Reference model: owner of the port (-1 none), who completed last, stall count.
  int         own  = -1;
  int         last = 1;
  int         cnt  = 0;
  logic [1:0] done = 2'b00;

  always begin : compare
    logic        r [2];
    logic        rq, to, e_cs, e_mrd, e_mwr, e_to;
    logic [31:0] e_ad, e_wd;
    logic [3:0]  e_be;
    logic        e_w [2];
    logic [31:0] e_srd [2];
    logic [1:0]  dn;
    @(negedge clk);
    #4;
    if (!rst_n) begin own = -1; last = 1; cnt = 0; end
    for (int n = 0; n < 2; n++) r[n] = cs_a[n] && (rd_a[n] || wr_a[n]);
    e_cs = 0; e_mrd = 0; e_mwr = 0; e_ad = '0; e_wd = '0; e_be = '0; e_to = 0;
    e_w[0] = 1; e_w[1] = 1; e_srd[0] = '0; e_srd[1] = '0; dn = 2'b00; rq = 0; to = 0;
    if (own >= 0) begin
      rq    = r[own];
      to    = rq && m_waitrequest && (cnt == TMO - 1);
      e_cs  = cs_a[own] && !to;
      e_mrd = rd_a[own] && !to;
      e_mwr = wr_a[own] && !to;
      e_ad  = ad_a[own];
      e_wd  = wd_a[own];
      e_be  = be_a[own];
      e_w[own]   = to ? 1'b0 : m_waitrequest;
      e_srd[own] = to ? TDATA : m_readdata;
      e_to  = to;
      dn[own] = rq && (!m_waitrequest || to);
    end
    chk("m_cs", m_cs, e_cs);
    chk("m_read", m_read, e_mrd);
    chk("m_write", m_write, e_mwr);
    chk("m_address", m_address, e_ad);
    chk("m_writedata", m_writedata, e_wd);
    chk("m_byteenable", m_byteenable, e_be);
    chk("s0_waitrequest", s0_waitrequest, e_w[0]);
    chk("s1_waitrequest", s1_waitrequest, e_w[1]);
    chk("s0_readdata", s0_readdata, e_srd[0]);
    chk("s1_readdata", s1_readdata, e_srd[1]);
    chk("timeout_o", timeout_o, e_to);
    done = dn;
    if (rst_n) begin
      if (own < 0) begin
        if (r[0] && r[1]) own = 1 - last;
        else if (r[0])    own = 0;
        else if (r[1])    own = 1;
        cnt = 0;
      end else if (!rq) begin
        own = -1; cnt = 0;
      end else if (!m_waitrequest || to) begin
        last = own; own = -1; cnt = 0;
      end else begin
        cnt++;
      end
    end
  end

  function automatic int grant_of(input logic w0, input logic w1);
    return !w0 ? 0 : (!w1 ? 1 : 3);
  endfunction

  initial begin : stim
    logic       act [2];
    int         stall_left;
    logic [2:0] rr;
    act[0] = 0; act[1] = 0; stall_left = 0;
    rst_n = 1'b0;
    drv(0, 0, 0, 0, '0, '0, '0);
    drv(1, 0, 0, 0, '0, '0, '0);
    m_waitrequest = 1'b0;
    m_readdata    = '0;

    // Reset values
    repeat (2) @(negedge clk);
    #3;
    chk("dir_rst_m_cs", {m_cs, m_read, m_write}, 3'b000);
    chk("dir_rst_m_bus", {m_address, m_byteenable}, 36'h0);
    chk("dir_rst_wait", {s0_waitrequest, s1_waitrequest}, 2'b11);
    chk("dir_rst_rdata", {s0_readdata, s1_readdata}, 64'h0);
    chk("dir_rst_timeout", timeout_o, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Continuous tie, zero-wait core: grants alternate 0,1,0,1 with an idle cycle between
    drv(0, 1, 1, 0, 32'h10, '0, 4'hF);
    drv(1, 1, 0, 1, 32'h20, 32'h55, 4'hF);
    for (int i = 0; i < 8; i++) begin
      m_readdata = $urandom;
      #3;
      if (i % 2 == 0) chk("dir_tie_idle", {s0_waitrequest, s1_waitrequest}, 2'b11);
      else            chk("dir_tie_order", grant_of(s0_waitrequest, s1_waitrequest), (i / 2) % 2);
      @(negedge clk);
    end
    drv(0, 0, 0, 0, '0, '0, '0);
    drv(1, 0, 0, 0, '0, '0, '0);

    // Single read from requester 0 with three stall cycles
    drv(0, 1, 1, 0, 32'h100, '0, 4'hF);
    m_waitrequest = 1'b1;
    #3;
    chk("dir_rd_idle", m_read, 1'b0);
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      m_waitrequest = (i < 3);
      m_readdata    = (i == 3) ? 32'h1234_5678 : 32'h0;
      #3;
      chk("dir_rd_m_read", m_read, 1'b1);
      chk("dir_rd_addr", m_address, 32'h100);
      chk("dir_rd_s1_wait", s1_waitrequest, 1'b1);
      chk("dir_rd_s0_wait", s0_waitrequest, (i < 3) ? 1'b1 : 1'b0);
      if (i == 3) chk("dir_rd_data", s0_readdata, 32'h1234_5678);
      @(negedge clk);
    end
    drv(0, 0, 0, 0, '0, '0, '0);

    // Write passthrough from requester 1
    drv(1, 1, 0, 1, 32'h200, 32'hCAFE_F00D, 4'b0011);
    m_waitrequest = 1'b0;
    #3;
    chk("dir_wr_idle", s1_waitrequest, 1'b1);
    @(negedge clk);
    #3;
    chk("dir_wr_strobes", {m_cs, m_read, m_write}, 3'b101);
    chk("dir_wr_addr", m_address, 32'h200);
    chk("dir_wr_data", m_writedata, 32'hCAFE_F00D);
    chk("dir_wr_be", m_byteenable, 4'b0011);
    chk("dir_wr_wait", {s0_waitrequest, s1_waitrequest}, 2'b10);
    @(negedge clk);
    drv(1, 0, 0, 0, '0, '0, '0);

    // Watchdog on a stalled requester-0 read, with requester 1 waiting behind it
    drv(0, 1, 1, 0, 32'h300, '0, 4'hF);
    m_waitrequest = 1'b1;
    @(negedge clk);
    drv(1, 1, 1, 0, 32'h304, '0, 4'hF);
    for (int i = 0; i < 8; i++) begin
      m_readdata = 32'h0000_1111;
      #3;
      if (i < 7) begin
        chk("dir_wd_quiet", {timeout_o, m_read, s0_waitrequest}, 3'b011);
      end else begin
        chk("dir_wd_pulse", timeout_o, 1'b1);
        chk("dir_wd_strobes", {m_cs, m_read}, 2'b00);
        chk("dir_wd_wait", {s0_waitrequest, s1_waitrequest}, 2'b01);
        chk("dir_wd_data", s0_readdata, 32'hDEAD_BEEF);
      end
      @(negedge clk);
    end
    drv(0, 0, 0, 0, '0, '0, '0);
    m_waitrequest = 1'b0;
    #3;
    chk("dir_wd_idle", {timeout_o, s1_waitrequest}, 2'b01);
    @(negedge clk);
    #3;
    chk("dir_wd_s1", {m_cs, m_read, s1_waitrequest}, 3'b110);
    chk("dir_wd_s1_addr", m_address, 32'h304);
    @(negedge clk);
    drv(1, 0, 0, 0, '0, '0, '0);

    // Requester 0 drops its read while stalled: no completion, last grant unchanged (1)
    drv(0, 1, 1, 0, 32'h400, '0, 4'hF);
    m_waitrequest = 1'b1;
    m_readdata    = 32'h0BAD_0BAD;
    @(negedge clk);
    #3;
    chk("dir_drop_stall", s0_waitrequest, 1'b1);
    @(negedge clk);
    drv(0, 1, 0, 0, 32'h400, '0, 4'hF);
    #3;
    chk("dir_drop_cycle", {timeout_o, m_read, s0_waitrequest}, 3'b001);
    @(negedge clk);
    drv(0, 1, 1, 0, 32'h500, '0, 4'hF);
    drv(1, 1, 1, 0, 32'h504, '0, 4'hF);
    m_waitrequest = 1'b0;
    #3;
    chk("dir_drop_idle", {timeout_o, s0_waitrequest, s1_waitrequest}, 3'b011);
    chk("dir_drop_rdata", s0_readdata, 32'h0);
    @(negedge clk);
    #3;
    chk("dir_drop_tie0", grant_of(s0_waitrequest, s1_waitrequest), 0);
    @(negedge clk);
    @(negedge clk);
    // Requester 1 holds the port; reset hits mid-transfer
    m_waitrequest = 1'b1;
    #1;
    chk("dir_rst_gnt1", grant_of(s0_waitrequest, s1_waitrequest), 3);
    chk("dir_rst_gnt1_cs", {m_cs, m_address}, {1'b1, 32'h504});
    #1;
    rst_n = 1'b0;
    #1;
    chk("dir_async_cs", m_cs, 1'b0);
    chk("dir_async_wait", {s0_waitrequest, s1_waitrequest}, 2'b11);
    @(negedge clk);
    rst_n = 1'b1;
    m_waitrequest = 1'b0;
    #3;
    chk("dir_post_rst_idle", {s0_waitrequest, s1_waitrequest}, 2'b11);
    @(negedge clk);
    #3;
    chk("dir_post_rst_tie0", grant_of(s0_waitrequest, s1_waitrequest), 0);
    @(negedge clk);
    drv(0, 0, 0, 0, '0, '0, '0);
    drv(1, 0, 0, 0, '0, '0, '0);

    // Random traffic against the model
    for (int k = 0; k < 4000; k++) begin
      @(negedge clk);
      for (int n = 0; n < 2; n++) begin
        if (act[n] && (done[n] || ($urandom % 64 == 0))) act[n] = 0;
        if (!act[n]) begin
          if ($urandom % 3 == 0) begin
            act[n] = 1;
            rr = 3'($urandom_range(1, 3));
            drv(n, 1, rr[0], rr[1], $urandom, $urandom, 4'($urandom));
          end else begin
            rr = 3'($urandom);
            drv(n, rr[0], !rr[0] && rr[1], !rr[0] && rr[2], $urandom, $urandom, 4'($urandom));
          end
        end
      end
      if (stall_left > 0) begin
        stall_left--;
        m_waitrequest = 1'b1;
      end else if ($urandom % 40 == 0) begin
        stall_left = 12;
        m_waitrequest = 1'b1;
      end else begin
        m_waitrequest = ($urandom % 3 == 0);
      end
      m_readdata = $urandom;
    end
    @(negedge clk);
    drv(0, 0, 0, 0, '0, '0, '0);
    drv(1, 0, 0, 0, '0, '0, '0);
    repeat (3) @(negedge clk);
    #4;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/avm_arb2.md
# avm_arb2

Two-requester Avalon-MM arbiter in front of the 32-bit Avalon-MM slave of the Qsys core (SDRAM and SPI master). It lets the NEORV32 bus bridge (requester 0) and a DMA/FatFs sector engine (requester 1) share that single port. Arbitration is round-robin with a registered grant. The grant is held for one complete transfer. A watchdog completes a transfer that stalls for too long and flags an error.

## Interface
- ADDR_W, 32, address width on all ports
- DATA_W, 32, data width; byteenable width is DATA_W/8
- TIMEOUT, 1024, maximum cycles a granted transfer may see m_waitrequest high; 0 disables the watchdog
- TIMEOUT_DATA, 32'hDEAD_BEEF, readdata returned on a timed-out read

Ports:
- clk_clk  in  1  single clock
- reset_reset_n  in  1  asynchronous, active-low reset
- sN_cs, sN_read, sN_write  in  1 each  requester N (N=0,1) select and strobes
- sN_address  in  ADDR_W  requester address
- sN_writedata  in  DATA_W  requester write data
- sN_byteenable  in  DATA_W/8  requester byte enables
- sN_waitrequest  out  1  stall to requester N
- sN_readdata  out  DATA_W  read data to requester N
- m_cs, m_read, m_write  out  1 each  to the core avm_cs_i / avm_read_i / avm_write_i
- m_address  out  ADDR_W  to the core address input
- m_writedata  out  DATA_W  to the core write-data input
- m_byteenable  out  DATA_W/8  to the core byte-enable input
- m_waitrequest  in  1  from avm_waitrequest_o
- m_readdata  in  DATA_W  from avm_readdata_o
- timeout_o  out  1  one-cycle pulse when the watchdog fires

## Operation
- Requester N is requesting (reqN) when sN_cs=1 and (sN_read or sN_write)=1.
- State machine: IDLE, GNT0, GNT1.
- IDLE:
  - Master outputs are all zero.
  - If only one requester is requesting, go to that requester's grant state.
  - If both are requesting, grant the requester that does not hold last_gnt.
  - last_gnt resets to 1, so requester 0 wins the first tie.
- GNTn:
  - m_cs, m_read, m_write, m_address, m_writedata and m_byteenable are combinational copies of requester n's signals. Read and write are forwarded unchanged.
  - sn_waitrequest = m_waitrequest.
  - sn_readdata = m_readdata.
  - The other requester sees waitrequest=1.
- Completion: in GNTn with m_waitrequest=0 and reqn=1, the transfer finishes. On that edge: last_gnt<=n, state->IDLE, watchdog cleared.
- Protocol violation: if reqn drops while in GNTn, the FSM goes to IDLE without completion and last_gnt is unchanged.
- Watchdog:
  - A counter increments on every GNTn cycle with m_waitrequest=1.
  - On the cycle the count equals TIMEOUT-1 with m_waitrequest still 1:
    - m_cs, m_read and m_write are forced to 0.
    - sn_waitrequest=0.
    - sn_readdata=TIMEOUT_DATA.
    - timeout_o=1.
  - That cycle is treated as a completion.
- Non-granted requesters always see sN_readdata = 0.

## Timing
- Reset values:
  - State IDLE, counter 0, last_gnt=1.
  - m_cs, m_read, m_write = 0; m_address, m_writedata, m_byteenable = 0.
  - s0_waitrequest = s1_waitrequest = 1.
  - s0_readdata = s1_readdata = 0; timeout_o = 0.
- Arbitration latency: 1 cycle. A request seen in IDLE at edge k is on the m_* port in cycle k+1.
- Minimum transfer is 2 cycles: arbitrate, then a GNT cycle with m_waitrequest=0.
- There is always at least one IDLE cycle between transfers. Back-to-back throughput is one transfer per 2 cycles at zero wait states.
- Readdata is valid only in the completing cycle (waitrequest low).
- Reset asserted mid-transfer: the FSM returns to IDLE immediately (async) and m_* outputs drop. The requester must reissue.
- Simultaneous completion and a new request from the other requester: the completion edge goes to IDLE; the new grant takes effect one cycle later.

## Test plan
- Single read, requester 0:
  - Stimulus: s0 read at 0x100; core waitrequest=1 for 3 cycles, then 0 with readdata 0x12345678.
  - Required: m_read high for 4 cycles; s0_readdata=0x12345678 on the completion cycle; s1_waitrequest=1 throughout.
- Tie round-robin:
  - Stimulus: both requesters assert continuously, zero-wait core.
  - Required: grant order after reset is 0,1,0,1; each transfer takes 2 cycles.
- Write passthrough:
  - Stimulus: s1 write of 0xCAFEF00D, byteenable 4'b0011, address 0x200.
  - Required: the m_* signals carry exactly those values during GNT1.
- Watchdog:
  - Stimulus: TIMEOUT=8, core waitrequest held at 1.
  - Required: on the 8th GNT cycle, timeout_o pulses, s0_waitrequest=0, s0_readdata=0xDEADBEEF, m_read=0; the FSM then serves a pending s1.
- Reset mid-transfer:
  - Stimulus: assert reset_reset_n=0 during GNT1.
  - Required: m_cs=0 and both waitrequests=1 asynchronously; after release, requester 0 wins the first tie.
- Requester drop:
  - Stimulus: s0 drops read while stalled.
  - Required: FSM returns to IDLE with no readdata and no timeout_o; last_gnt is unchanged.
